// File: rtl/sub_word_memory_if.sv
// rtl/sub_word_memory_if.sv - request/response bus for sub_word_memory
//
// Purpose: groups the load/store request handshake and the one-cycle
// response of sub_word_memory.
// Ports (signals):
//   req_valid/req_ready      request handshake
//   req_write, req_size,     store/load select, access size, load extension
//   req_unsigned
//   address, data            byte address, right-aligned store data
//   resp_valid, mem_result,  one-cycle response pulse, load result, error flag
//   fault
interface sub_word_memory_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] data;
  logic        resp_valid;
  logic [31:0] mem_result;
  logic        fault;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, data,
    input  req_ready, resp_valid, mem_result, fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, data,
    output req_ready, resp_valid, mem_result, fault
  );
endinterface

// File: rtl/sub_word_memory.sv
// rtl/sub_word_memory.sv - byte/half/word addressable 32-bit memory
//
// Purpose: DEPTH x 32-bit little-endian memory mapped at BASE_ADDR with
// byte, half and word loads/stores, fixed one-cycle response latency and
// an optional zero-fill sequence after reset.
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   bus        sub_word_memory_if.slave request/response bus
//   init_done  high once the clear sequence has finished
module sub_word_memory #(
  parameter int          DEPTH          = 64,
  parameter logic [31:0] BASE_ADDR      = 32'd1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sub_word_memory_if.slave  bus,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? INIT : READY;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  clr_cnt;
  logic           clr_we;
  logic           ready_int;

  logic [31:0]    mem [DEPTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET_STATE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_cnt == AW'(DEPTH - 1)) state_nxt = READY;
  end

  // Outputs are gated with rst so that they read idle while reset is held,
  // even when the reset state is READY (CLEAR_ON_RESET=0).
  always_comb begin
    ready_int = 1'b0;
    init_done = 1'b0;
    clr_we    = 1'b0;
    case (state)
      INIT:    clr_we = rst;
      READY: begin
        ready_int = rst;
        init_done = rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               clr_cnt <= '0;
    else if (state == INIT) clr_cnt <= clr_cnt + AW'(1);
    else                    clr_cnt <= '0;
  end

  assign bus.req_ready = ready_int;

  // ------------------------------------------------------------- decode
  logic [31:0]   offset;
  logic          fault_c;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          accept;
  logic          st_we;

  assign offset = bus.address - BASE_ADDR;
  assign lane   = bus.address[1:0];
  assign idx    = offset[AW+1:2];

  always_comb begin
    fault_c = 1'b0;
    if (bus.address < BASE_ADDR)             fault_c = 1'b1;
    if ((offset >> 2) >= 32'(DEPTH))          fault_c = 1'b1;
    if (bus.req_size == 2'b11)               fault_c = 1'b1;
    if (bus.req_size == 2'b01 && lane[0])    fault_c = 1'b1;
    if (bus.req_size == 2'b10 && lane != 2'b00) fault_c = 1'b1;
  end

  assign accept = bus.req_valid & ready_int;
  assign st_we  = accept & bus.req_write & ~fault_c;

  // -------------------------------------------------------- data paths
  logic [31:0] rd_word;
  logic [15:0] sel_half;
  logic [7:0]  sel_byte;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] mask;
  logic [31:0] merged;

  // Asynchronous read: a store on edge N is visible to a load on edge N+1.
  assign rd_word  = mem[idx];
  assign sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign sel_byte = lane[0] ? sel_half[15:8] : sel_half[7:0];

  always_comb begin
    load_val = rd_word;
    case (bus.req_size)
      2'b00:   load_val = bus.req_unsigned ? {24'b0, sel_byte}
                                           : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_val = bus.req_unsigned ? {16'b0, sel_half}
                                           : {{16{sel_half[15]}}, sel_half};
      default: load_val = rd_word;
    endcase
  end

  // Store data is replicated across lanes and merged under a byte mask.
  always_comb begin
    be        = 4'hF;
    wdata_rep = bus.data;
    case (bus.req_size)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{bus.data[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {lane[1], 1'b0};
        wdata_rep = {2{bus.data[15:0]}};
      end
      default: ;
    endcase
  end

  assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged = (rd_word & ~mask) | (wdata_rep & mask);

  // Memory has no reset; only the INIT sequence zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_cnt] <= '0;
    else if (st_we) mem[idx]     <= merged;
  end

  // ---------------------------------------------------------- response
  logic        resp_q;
  logic        fault_q;
  logic [31:0] result_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q   <= 1'b0;
      fault_q  <= 1'b0;
      result_q <= '0;
    end else begin
      resp_q   <= accept;
      fault_q  <= accept & fault_c;
      result_q <= (accept & ~bus.req_write & ~fault_c) ? load_val : '0;
    end
  end

  assign bus.resp_valid = resp_q;
  assign bus.fault      = fault_q;
  assign bus.mem_result = result_q;

endmodule
